bcd_date_sequencer: RTL and testbench

- Two-digit-year calendar sequencer. Holds the current date as BCD digits and advances it by one day per Tick.
- Applies the leap-year rule through a divisible-by-four check on the BCD year digits, which selects a 28- or 29-day February.
- Supports a validated load of a new date.
- Feeds display and report logic downstream.

---
 rtl/bcd_date_sequencer.sv | 148 ++++++++++++++
 tb/tb_bcd_date_sequencer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/bcd_date_sequencer.sv
// Two-digit-year BCD calendar: advances one day per Tick and accepts validated date loads.
// Leap years are found from the BCD year digits directly, so no binary conversion is needed.
module bcd_date_sequencer #(
    parameter logic [7:0] RESET_DAY   = 8'h01,
    parameter logic [7:0] RESET_MONTH = 8'h01,
    parameter logic [7:0] RESET_YEAR  = 8'h00
) (
    input  logic       Clock,
    input  logic       Reset_N,
    input  logic       Tick,
    input  logic       Load,
    input  logic [7:0] LoadDay,
    input  logic [7:0] LoadMonth,
    input  logic [7:0] LoadYear,
    output logic       LoadReady,
    output logic [7:0] Day,
    output logic [7:0] Month,
    output logic [7:0] Year,
    output logic       Leap,
    output logic       Rollover,
    output logic       LoadError
);

    typedef enum logic {RUN, CHECK} state_t;

    state_t     state, state_nxt;
    logic       pend;
    logic [7:0] stg_day, stg_month, stg_year;
    logic [7:0] inc_day, inc_month, inc_year;
    logic       inc_wrap;
    logic       stg_valid;

    // Divisible by 4: even tens need ones in {0,4,8}, odd tens need ones in {2,6}.
    function automatic logic is_leap(input logic [7:0] y);
        if (y[4]) return (y[3:0] == 4'd2) || (y[3:0] == 4'd6);
        else      return (y[3:0] == 4'd0) || (y[3:0] == 4'd4) || (y[3:0] == 4'd8);
    endfunction

    function automatic logic [7:0] month_len(input logic [7:0] m, input logic lp);
        case (m)
            8'h04, 8'h06, 8'h09, 8'h11: month_len = 8'h30;
            8'h02:                      month_len = lp ? 8'h29 : 8'h28;
            default:                    month_len = 8'h31;
        endcase
    endfunction

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
        else                return {v[7:4], v[3:0] + 4'd1};
    endfunction

    assign Leap = is_leap(Year);

    always_comb begin
        inc_day   = bcd_inc(Day);
        inc_month = Month;
        inc_year  = Year;
        inc_wrap  = 1'b0;
        if (Day == month_len(Month, Leap)) begin
            inc_day = 8'h01;
            if (Month == 8'h12) begin
                inc_month = 8'h01;
                if (Year == 8'h99) begin
                    inc_year = 8'h00;
                    inc_wrap = 1'b1;
                end else begin
                    inc_year = bcd_inc(Year);
                end
            end else begin
                inc_month = bcd_inc(Month);
            end
        end
    end

    // Once every digit is known to be 0..9, plain unsigned compares order BCD values correctly.
    always_comb begin
        stg_valid = (stg_day[7:4]   <= 4'd9) && (stg_day[3:0]   <= 4'd9) &&
                    (stg_month[7:4] <= 4'd9) && (stg_month[3:0] <= 4'd9) &&
                    (stg_year[7:4]  <= 4'd9) && (stg_year[3:0]  <= 4'd9) &&
                    (stg_month >= 8'h01) && (stg_month <= 8'h12) &&
                    (stg_day >= 8'h01) &&
                    (stg_day <= month_len(stg_month, is_leap(stg_year)));
    end

    always_ff @(posedge Clock or negedge Reset_N) begin
        if (!Reset_N) state <= RUN;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        LoadReady = 1'b0;
        case (state)
            RUN: begin
                LoadReady = 1'b1;
                if (Load) state_nxt = CHECK;
            end
            CHECK:   state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset_N) begin
        if (!Reset_N) begin
            Day       <= RESET_DAY;
            Month     <= RESET_MONTH;
            Year      <= RESET_YEAR;
            pend      <= 1'b0;
            stg_day   <= 8'h00;
            stg_month <= 8'h00;
            stg_year  <= 8'h00;
            Rollover  <= 1'b0;
            LoadError <= 1'b0;
        end else begin
            Rollover  <= 1'b0;
            LoadError <= 1'b0;
            case (state)
                RUN: begin
                    if (Load) begin
                        stg_day   <= LoadDay;
                        stg_month <= LoadMonth;
                        stg_year  <= LoadYear;
                        pend      <= pend | Tick;
                    end else if (pend | Tick) begin
                        Day      <= inc_day;
                        Month    <= inc_month;
                        Year     <= inc_year;
                        Rollover <= inc_wrap;
                        // A fresh tick arriving with a pending one stays queued for next cycle.
                        pend     <= pend & Tick;
                    end
                end
                CHECK: begin
                    pend <= pend | Tick;
                    if (stg_valid) begin
                        Day   <= stg_day;
                        Month <= stg_month;
                        Year  <= stg_year;
                    end else begin
                        LoadError <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_date_sequencer.sv
// Scoreboard bench: stimulus pushes expected date events, a negedge monitor pops and compares.
module tb_bcd_date_sequencer;

    logic       Clock, Reset_N, Tick, Load;
    logic [7:0] LoadDay, LoadMonth, LoadYear;
    logic       LoadReady, Leap, Rollover, LoadError;
    logic [7:0] Day, Month, Year;

    bcd_date_sequencer dut (
        .Clock(Clock), .Reset_N(Reset_N), .Tick(Tick), .Load(Load),
        .LoadDay(LoadDay), .LoadMonth(LoadMonth), .LoadYear(LoadYear),
        .LoadReady(LoadReady), .Day(Day), .Month(Month), .Year(Year),
        .Leap(Leap), .Rollover(Rollover), .LoadError(LoadError)
    );

    typedef struct packed {
        logic [7:0] d, m, y;
        logic       leap, roll, err;
    } ev_t;

    ev_t        sbq[$];
    ev_t        got, want;
    logic [23:0] prev;
    int         checks = 0, errors = 0;
    int         cd, cm, cy;

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    function automatic int dim(int m, int y);
        case (m)
            4, 6, 9, 11: return 30;
            2:           return (y % 4 == 0) ? 29 : 28;
            default:     return 31;
        endcase
    endfunction

    function automatic int b2i(logic [7:0] b);
        return int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    function automatic logic [7:0] i2b(int v);
        logic [3:0] t, o;
        t = 4'(v / 10);
        o = 4'(v % 10);
        return {t, o};
    endfunction

    function automatic bit date_ok(logic [7:0] d, logic [7:0] m, logic [7:0] y);
        int di, mi, yi;
        if (d[7:4] > 9 || d[3:0] > 9 || m[7:4] > 9 || m[3:0] > 9 || y[7:4] > 9 || y[3:0] > 9)
            return 1'b0;
        di = b2i(d); mi = b2i(m); yi = b2i(y);
        if (mi < 1 || mi > 12) return 1'b0;
        return (di >= 1) && (di <= dim(mi, yi));
    endfunction

    task automatic push_ev(bit roll, bit err);
        ev_t e;
        e.d = i2b(cd); e.m = i2b(cm); e.y = i2b(cy);
        e.leap = (cy % 4 == 0); e.roll = roll; e.err = err;
        sbq.push_back(e);
    endtask

    task automatic model_tick();
        bit roll;
        roll = 1'b0;
        if (cd == dim(cm, cy)) begin
            cd = 1;
            if (cm == 12) begin
                cm = 1;
                cy = (cy + 1) % 100;
                roll = (cy == 0);
            end else cm = cm + 1;
        end else cd = cd + 1;
        push_ev(roll, 1'b0);
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle(int n);
        repeat (n) begin @(posedge Clock); #1; end
    endtask

    task automatic do_tick();
        Tick = 1'b1;
        model_tick();
        idle(1);
        Tick = 1'b0;
        idle(1);
    endtask

    task automatic do_load(logic [7:0] d, logic [7:0] m, logic [7:0] y, bit t);
        Load = 1'b1; LoadDay = d; LoadMonth = m; LoadYear = y; Tick = t;
        if (date_ok(d, m, y)) begin
            if (b2i(d) != cd || b2i(m) != cm || b2i(y) != cy) begin
                cd = b2i(d); cm = b2i(m); cy = b2i(y);
                push_ev(1'b0, 1'b0);
            end
        end else push_ev(1'b0, 1'b1);
        if (t) model_tick();
        idle(1);
        Load = 1'b0; Tick = 1'b0;
        idle(3);
    endtask

    // Monitor: any date change or pulse is an observable event and must match the queue head.
    always @(negedge Clock) begin
        if (!Reset_N) begin
            prev = {Day, Month, Year};
        end else if ({Day, Month, Year} != prev || Rollover || LoadError) begin
            got = '{d: Day, m: Month, y: Year, leap: Leap, roll: Rollover, err: LoadError};
            checks++;
            if (sbq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event: got %h/%h/%h leap=%b roll=%b err=%b",
                         Day, Month, Year, Leap, Rollover, LoadError);
            end else begin
                want = sbq.pop_front();
                if (got !== want) begin
                    errors++;
                    $display("FAIL event: got %h/%h/%h leap=%b roll=%b err=%b expected %h/%h/%h leap=%b roll=%b err=%b",
                             got.d, got.m, got.y, got.leap, got.roll, got.err,
                             want.d, want.m, want.y, want.leap, want.roll, want.err);
                end
            end
            prev = {Day, Month, Year};
        end
    end

    initial begin
        int r, y, m, d;
        Reset_N = 1'b0; Tick = 1'b0; Load = 1'b0;
        LoadDay = 8'h00; LoadMonth = 8'h00; LoadYear = 8'h00;
        cd = 1; cm = 1; cy = 0;
        idle(3);
        Reset_N = 1'b1;
        idle(2);
        chk("reset_day", 32'(Day), 32'h01);
        chk("reset_month", 32'(Month), 32'h01);
        chk("reset_year", 32'(Year), 32'h00);
        chk("reset_leap", 32'(Leap), 32'h1);
        chk("reset_loadready", 32'(LoadReady), 32'h1);
        chk("reset_rollover", 32'(Rollover), 32'h0);
        chk("reset_loaderror", 32'(LoadError), 32'h0);

        // February and century boundaries
        do_load(8'h28, 8'h02, 8'h24, 1'b0); do_tick(); do_tick();
        do_load(8'h28, 8'h02, 8'h23, 1'b0); do_tick();
        do_load(8'h28, 8'h02, 8'h00, 1'b0); do_tick();
        do_load(8'h31, 8'h12, 8'h99, 1'b0); do_tick();
        // Rejected loads
        do_load(8'h29, 8'h02, 8'h23, 1'b0);
        do_load(8'h31, 8'h04, 8'h10, 1'b0);
        do_load(8'h1A, 8'h05, 8'h10, 1'b0);
        do_load(8'h15, 8'h13, 8'h10, 1'b0);
        // Load with coincident tick
        do_load(8'h30, 8'h06, 8'h50, 1'b1);

        // Load held into the CHECK cycle is dropped
        Load = 1'b1; LoadDay = 8'h10; LoadMonth = 8'h10; LoadYear = 8'h10;
        cd = 10; cm = 10; cy = 10; push_ev(1'b0, 1'b0);
        idle(1);
        chk("loadready_in_check", 32'(LoadReady), 32'h0);
        LoadDay = 8'h20; LoadMonth = 8'h11; LoadYear = 8'h11;
        idle(1);
        Load = 1'b0;
        chk("loadready_after_check", 32'(LoadReady), 32'h1);
        idle(3);

        // Async reset while a load is being checked
        Load = 1'b1; LoadDay = 8'h15; LoadMonth = 8'h08; LoadYear = 8'h12;
        idle(1);
        Load = 1'b0; Reset_N = 1'b0;
        #1;
        chk("rst_check_day", 32'(Day), 32'h01);
        chk("rst_check_month", 32'(Month), 32'h01);
        chk("rst_check_year", 32'(Year), 32'h00);
        chk("rst_check_loaderror", 32'(LoadError), 32'h0);
        cd = 1; cm = 1; cy = 0;
        idle(2);
        Reset_N = 1'b1;
        idle(2);
        do_tick();

        // Randomized mix of ticks, month-end loads and garbage loads
        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 9);
            if (r < 5) begin
                do_tick();
            end else if (r < 8) begin
                y = $urandom_range(0, 99);
                m = $urandom_range(1, 12);
                d = ($urandom_range(0, 1) == 0) ? dim(m, y) - $urandom_range(0, 1)
                                                : $urandom_range(1, dim(m, y));
                do_load(i2b(d), i2b(m), i2b(y), 1'($urandom_range(0, 1)));
            end else begin
                do_load(8'($urandom), 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
            end
        end
        idle(5);
        chk("scoreboard_drained", 32'(sbq.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
